// File: rtl/decoder_pkg.sv
// Shared widths and state encoding for the 3-to-8 decoder / 8-to-3 encoder pair.
// CODE_W and ONEHOT_W are also used by the encoder side, so the two directions
// always agree on the binary and one-hot widths.
package decoder_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/decoder3x8.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   en    - enable; y is all-zero when low
//   code  - binary code 0..7
//   y     - one-hot result, bit 'code' set when enabled
module decoder3x8
  import decoder_pkg::*;
(
  input  logic                en,
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y = ONEHOT_W'(1) << code;
    end
  end

endmodule

// File: rtl/decoder3x8_strobe.sv
// Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a
// timed output strobe. Each accepted code holds one output line high for
// PULSE_LEN cycles, then releases it and pulses done for one cycle.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous, active-high reset
//   in_valid  - in_code is presented
//   in_code   - binary code 0..7
//   in_ready  - block can accept a code this cycle (from state register only)
//   out       - registered one-hot strobe, all-zero when idle
//   out_valid - high while out drives a code
//   done      - one-cycle pulse in the first idle cycle after a strobe
module decoder3x8_strobe
  import decoder_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   in_code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_valid,
  output logic                done
);

  localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  if (PULSE_LEN < 1 || PULSE_LEN > 256) begin : g_bad_pulse_len
    $error("decoder3x8_strobe: PULSE_LEN must be in 1..256");
  end

  state_t              state_q, state_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic [ONEHOT_W-1:0] dec_y;

  // Gating the decoder with the handshake keeps an X on in_code (while
  // in_valid is low) from ever reaching the output register.
  assign accept = in_valid && (state_q == IDLE);

  decoder3x8 u_dec (
    .en   (accept),
    .code (in_code),
    .y    (dec_y)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          out_d       = dec_y;
          out_valid_d = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        // Counter starts at PULSE_LEN-1, so the release edge falls after
        // exactly PULSE_LEN cycles of a driven output.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: doc/decoder3x8_strobe.md
Name: decoder3x8_strobe

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a timed output strobe. It is the inverse direction of the team's 8x3 encoder.
- Each accepted 3-bit code drives exactly one output line high for PULSE_LEN cycles, then releases it and pulses done.
- Used to fire one-hot select/strobe lines (chip selects, mux enables, LED/segment drivers) from a compact binary code.

Parameters:
- PULSE_LEN, 4, cycles the one-hot output is held per accepted code; legal range 1..256. Any other value is an elaboration error.
- CNT_W, derived localparam = max(1, $clog2(PULSE_LEN)), width of the hold counter. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_code is presented.
- in_code  input  3  binary code 0..7 to decode.
- in_ready  output  1  block can accept a code this cycle.
- out  output  8  one-hot decoded strobe; all-zero when idle.
- out_valid  output  1  high while out is driving a code.
- done  output  1  one-cycle pulse when a strobe finishes.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, out=8'h00, out_valid=0, done=0, counter=0. in_ready=1 in the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1.
  - ACTIVE: in_ready=0.
- in_ready is decoded from the state register only. There is no combinational path from in_valid or in_code to any output.
- Accept: a handshake occurs on an edge where in_valid=1 and in_ready=1. On that edge:
  - out <= 8'b1 << in_code, out_valid <= 1;
  - counter <= PULSE_LEN-1;
  - state <= ACTIVE.
- Latency: out is valid the cycle after the accept edge. Accept-to-out latency is 1 cycle.
- ACTIVE with counter != 0: out holds, counter decrements, in_valid and in_code are ignored.
- ACTIVE with counter == 0: on the next edge out <= 0, out_valid <= 0, done <= 1, state <= IDLE.
- done is high for exactly one cycle, which is the first IDLE cycle. It is 0 in every other cycle.
- Result: out is one-hot for exactly PULSE_LEN consecutive cycles per accepted code.
- Back-to-back codes: in the done cycle in_ready=1, so a new code may be accepted there. There is a minimum 1-cycle all-zero gap between strobes. Throughput is one code per PULSE_LEN+1 cycles.
- PULSE_LEN=1: out is one-hot for a single cycle, then done. The counter is never decremented.
- Invariant: out is always either all-zero or exactly one-hot, and out_valid == |out.
- in_code when in_valid=0: ignored, may be X, must not propagate.
- No retrigger: codes presented while ACTIVE are not queued. The source must hold in_valid until it sees in_ready.
- Reset mid-strobe: the next edge forces out=0, out_valid=0, done=0, state=IDLE. No done pulse is produced for the aborted strobe.
- rst overrides a simultaneous handshake: a code presented with in_valid=1 in the rst cycle is dropped.

Decomposition:
- Shared package decoder_pkg:
  - CODE_W=3, ONEHOT_W=8;
  - state typedef {IDLE, ACTIVE}.
- The encoder side reuses the package widths.
- Sub-module decoder3x8: a purely combinational binary-to-one-hot decoder (en, code[2:0] -> y[7:0]). Its output is all-zero when en=0.
- Top-level decoder3x8_strobe contains:
  - the FSM and hold counter;
  - the output register, loaded from the decoder3x8 result on accept and cleared on release.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1, in_code=5 -> out=8'h00, out_valid=0, done=0 throughout; in_ready=1 the cycle after rst drops.
- Single code, PULSE_LEN=4: accept in_code=3 at edge N -> out=8'h08 in cycles N+1..N+4, out=0 and done=1 at N+5, in_ready=0 in N+1..N+4.
- Sweep with in_valid held high, codes 0..7 -> out sequence 01,02,04,08,10,20,40,80. Each held 4 cycles, one 00/done cycle between, eight done pulses total.
- Ignore while busy: present in_code=6 during ACTIVE of code 1 and hold in_valid -> out stays 8'h02 until release, then 8'h40 starts the cycle after done.
- Reset mid-strobe: accept code 7, assert rst at the 2nd active cycle -> out=0 next cycle, no done pulse, in_ready=1 after rst drops.
- PULSE_LEN=1 build: continuous valid codes 2,4 -> out=04, 00 with done=1, 10, 00 with done=1. Check the one-hot invariant every cycle.
